// File: rtl/cordic_vectoring_if.sv
// Sample/result handshake bundle for the CORDIC vectoring core.
// The slave side is the core; the master side is whatever feeds it and drains it.
interface cordic_vectoring_if #(
  parameter int IN_WIDTH   = 16,
  parameter int EXTRA_BITS = 6
);
  localparam int WM = IN_WIDTH + EXTRA_BITS + 2;

  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_WIDTH-1:0] x_in;
  logic signed [IN_WIDTH-1:0] y_in;
  logic                       out_valid;
  logic                       out_ready;
  logic        [WM-1:0]       mag;
  logic        [31:0]         phase;

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag, phase
  );

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag, phase
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) -> magnitude and 32-bit binary-angle phase.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that removes the CORDIC gain from mag.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// PRE   | rotate sample into the right half plane, detect the all-zero input
// ITER  | one micro-rotation per cycle, i = 0..ITERS-1
// GAIN  | multiply x by 1/K (only with CORDIC_GAIN_COMP_EN)
// DONE  | out_valid high, result held until out_ready
module cordic_vectoring #(
  parameter int IN_WIDTH   = 16,
  parameter int EXTRA_BITS = 6,
  parameter int ITERS      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cordic_vectoring_if.slave     bus
);
  localparam int WM = IN_WIDTH + EXTRA_BITS + 2;

  typedef enum logic [2:0] {IDLE, PRE, ITER, GAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [WM-1:0]  x_q, x_d, y_q, y_d, xs, ys;
  logic        [31:0]    z_q, z_d;
  logic        [4:0]     cnt_q, cnt_d;
  logic                  zero_q, zero_d;
  logic        [WM-1:0]  mag_q, mag_d;
  logic        [31:0]    phase_q, phase_d;

  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h20000000;
      5'd1:  return 32'h12E4051D;
      5'd2:  return 32'h09FB385B;
      5'd3:  return 32'h051111D4;
      5'd4:  return 32'h028B0D43;
      5'd5:  return 32'h0145D7E1;
      5'd6:  return 32'h00A2F61E;
      5'd7:  return 32'h00517C55;
      5'd8:  return 32'h0028BE53;
      5'd9:  return 32'h00145F2E;
      5'd10: return 32'h000A2F98;
      5'd11: return 32'h000517CC;
      5'd12: return 32'h00028BE6;
      5'd13: return 32'h000145F3;
      5'd14: return 32'h0000A2F9;
      5'd15: return 32'h0000517C;
      5'd16: return 32'h000028BE;
      5'd17: return 32'h0000145F;
      5'd18: return 32'h00000A2F;
      5'd19: return 32'h00000517;
      5'd20: return 32'h0000028B;
      5'd21: return 32'h00000145;
      5'd22: return 32'h000000A2;
      5'd23: return 32'h00000051;
      5'd24: return 32'h00000028;
      5'd25: return 32'h00000014;
      5'd26: return 32'h0000000A;
      5'd27: return 32'h00000005;
      5'd28: return 32'h00000002;
      5'd29: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // 1/K in Q2.30; x is non-negative here so the product never needs rounding toward zero
  localparam logic [31:0] GAIN_K = 32'h26dd3b6a;
  logic signed [WM+32:0] x_ext, k_ext, prod;
  logic signed [WM-1:0]  x_gain;
  assign x_ext  = {{33{x_q[WM-1]}}, x_q};
  assign k_ext  = {{(WM+1){1'b0}}, GAIN_K};
  assign prod   = x_ext * k_ext;
  assign x_gain = prod[WM+29:30];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = PRE;
      PRE:  state_d = ITER;
      ITER: if (cnt_q == 5'(ITERS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
        state_d = GAIN;
`else
        state_d = DONE;
`endif
      end
      GAIN: state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    xs      = x_q >>> cnt_q;
    ys      = y_q >>> cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        x_d   = {{(WM-IN_WIDTH){bus.x_in[IN_WIDTH-1]}}, bus.x_in} <<< EXTRA_BITS;
        y_d   = {{(WM-IN_WIDTH){bus.y_in[IN_WIDTH-1]}}, bus.y_in} <<< EXTRA_BITS;
        cnt_d = '0;
      end
      PRE: begin
        zero_d = (x_q == '0) && (y_q == '0);
        if (!x_q[WM-1]) begin
          z_d = 32'h00000000;
        end else if (!y_q[WM-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = 32'h40000000;
        end else begin
          x_d = -y_q;
          y_d = x_q;
          z_d = 32'hC0000000;
        end
      end
      ITER: begin
        if (!y_q[WM-1]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_lut(cnt_q);
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_lut(cnt_q);
        end
        cnt_d = cnt_q + 5'd1;
      end
`ifdef CORDIC_GAIN_COMP_EN
      GAIN: x_d = x_gain;
`endif
      default: ;
    endcase
    // result registers load once, on the way into DONE, so they stay frozen under back-pressure
    if (state_d == DONE && state_q != DONE) begin
      mag_d   = zero_d ? '0 : x_d;
      phase_d = zero_d ? '0 : z_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.mag       = mag_q;
  assign bus.phase     = phase_q;
endmodule
